// File: rtl/layer_fetch_sched_pkg.sv
// Shared types and constants for the per-pixel layer fetch scheduler.
// Holds the ROM/colour widths, FSM encoding and the small records passed between processes.
package layer_fetch_sched_pkg;

    localparam int ADDR_W     = 17;
    localparam int COLOR_W    = 12;
    localparam int LAYER_ID_W = 2;

    localparam logic [COLOR_W-1:0] TRANSPARENT_TEXEL = 12'hF0F;
    localparam logic [COLOR_W-1:0] BG_COLOR_DEFAULT  = 12'h000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic                  valid;
        logic [LAYER_ID_W-1:0] id;
    } pipe_entry_t;

    typedef struct packed {
        logic [COLOR_W-1:0]    color;
        logic                  hit;
        logic [LAYER_ID_W-1:0] layer;
    } pix_result_t;

    function automatic logic texel_opaque(input logic [COLOR_W-1:0] texel,
                                          input logic [COLOR_W-1:0] key);
        return texel != key;
    endfunction

endpackage

// File: rtl/layer_fetch_sched_prio_pick.sv
// Combinational priority picker: finds the lowest set bit of a pending mask,
// reports its index and the mask with that bit removed.
module layer_prio_pick
    import layer_fetch_sched_pkg::*;
#(
    parameter int N_LAYERS = 3
) (
    input  logic [N_LAYERS-1:0]   mask_i,
    output logic                  any_o,
    output logic [LAYER_ID_W-1:0] index_o,
    output logic [N_LAYERS-1:0]   rest_o
);

    logic [N_LAYERS-1:0] lowest;

    // Two's-complement trick isolates the lowest set bit, i.e. the highest-priority layer.
    assign lowest = mask_i & (~mask_i + N_LAYERS'(1));
    assign any_o  = |mask_i;
    assign rest_o = mask_i & ~lowest;

    always_comb begin
        index_o = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (lowest[i]) begin
                index_o = LAYER_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/layer_fetch_sched.sv
// Shares one single-port image ROM among several layers within a pixel slot;
// the first opaque texel in priority order wins and is committed at the next tick.
module layer_fetch_sched
    import layer_fetch_sched_pkg::*;
#(
    parameter int                 N_LAYERS    = 3,
    parameter int                 CLK_PER_PIX = 4,
    parameter logic [COLOR_W-1:0] TRANSPARENT = TRANSPARENT_TEXEL,
    parameter logic [COLOR_W-1:0] BG_COLOR    = BG_COLOR_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pix_tick,
    input  logic [N_LAYERS-1:0]          layer_en,
    input  logic [ADDR_W*N_LAYERS-1:0]   layer_addr,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [COLOR_W-1:0]           rom_data,
    output logic [COLOR_W-1:0]           pix_color,
    output logic                         pix_hit,
    output logic [LAYER_ID_W-1:0]        pix_layer,
    output logic                         overrun
);

    // A slot has CLK_PER_PIX cycles, and each layer needs one issue plus one check cycle.
    if (N_LAYERS < 1 || N_LAYERS >= CLK_PER_PIX || N_LAYERS > (1 << LAYER_ID_W)) begin : g_bad_cfg
        $error("layer_fetch_sched: N_LAYERS must lie in 1..CLK_PER_PIX-1");
    end

    sched_state_e                     state_q, state_d;
    logic [N_LAYERS-1:0]              pending_q, pending_d;
    logic [N_LAYERS-1:0][ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]                rom_addr_q, rom_addr_d;
    pipe_entry_t                      pipe_q, pipe_d;
    logic                             found_q, found_d;
    logic [COLOR_W-1:0]               win_color_q, win_color_d;
    logic [LAYER_ID_W-1:0]            win_id_q, win_id_d;
    pix_result_t                      pix_q, pix_d;
    logic                             overrun_q, overrun_d;

    logic [N_LAYERS-1:0][ADDR_W-1:0]  layer_addr_vec;
    logic                             tick_any, issue_any, next_any;
    logic [LAYER_ID_W-1:0]            tick_idx, issue_idx, next_idx;
    logic [N_LAYERS-1:0]              tick_rest, issue_rest, next_rest;
    logic                             check_hit, found_now;
    logic                             unused_pick_rest;

    assign layer_addr_vec = layer_addr;

    layer_prio_pick #(.N_LAYERS(N_LAYERS)) u_pick_tick (
        .mask_i  (layer_en),
        .any_o   (tick_any),
        .index_o (tick_idx),
        .rest_o  (tick_rest)
    );

    layer_prio_pick #(.N_LAYERS(N_LAYERS)) u_pick_issue (
        .mask_i  (pending_q),
        .any_o   (issue_any),
        .index_o (issue_idx),
        .rest_o  (issue_rest)
    );

    // Looks one layer ahead so rom_addr is already set up for the next issue cycle.
    layer_prio_pick #(.N_LAYERS(N_LAYERS)) u_pick_next (
        .mask_i  (issue_rest),
        .any_o   (next_any),
        .index_o (next_idx),
        .rest_o  (next_rest)
    );

    assign unused_pick_rest = ^{tick_rest, next_rest};

    assign check_hit = pipe_q.valid & ~found_q & texel_opaque(rom_data, TRANSPARENT);
    assign found_now = found_q | check_hit;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        addr_d      = addr_q;
        rom_addr_d  = rom_addr_q;
        pipe_d      = '0;
        found_d     = found_q;
        win_color_d = win_color_q;
        win_id_d    = win_id_q;
        pix_d       = pix_q;
        overrun_d   = overrun_q;

        if (check_hit) begin
            found_d     = 1'b1;
            win_color_d = rom_data;
            win_id_d    = pipe_q.id;
        end

        if (pix_tick) begin
            // The tick cycle's own check still counts toward the slot being committed.
            if (found_q) begin
                pix_d = '{color: win_color_q, hit: 1'b1, layer: win_id_q};
            end else if (check_hit) begin
                pix_d = '{color: rom_data, hit: 1'b1, layer: pipe_q.id};
            end else begin
                pix_d = '{color: BG_COLOR, hit: 1'b0, layer: '0};
            end
            if ((pending_q != '0) && !found_now) begin
                overrun_d = 1'b1;
            end
            pending_d = layer_en;
            addr_d    = layer_addr_vec;
            if (tick_any) begin
                rom_addr_d = layer_addr_vec[tick_idx];
            end
            found_d = 1'b0;
            state_d = ST_ISSUE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ISSUE: begin
                    if (issue_any && !found_now) begin
                        pending_d = issue_rest;
                        pipe_d    = '{valid: 1'b1, id: issue_idx};
                        if (next_any) begin
                            rom_addr_d = addr_q[next_idx];
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    state_d = ST_HOLD;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            addr_q      <= '0;
            rom_addr_q  <= '0;
            pipe_q      <= '0;
            found_q     <= 1'b0;
            win_color_q <= '0;
            win_id_q    <= '0;
            pix_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            addr_q      <= addr_d;
            rom_addr_q  <= rom_addr_d;
            pipe_q      <= pipe_d;
            found_q     <= found_d;
            win_color_q <= win_color_d;
            win_id_q    <= win_id_d;
            pix_q       <= pix_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pix_color = pix_q.color;
    assign pix_hit   = pix_q.hit;
    assign pix_layer = pix_q.layer;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_layer_fetch_sched.sv
// Self-checking bench for layer_fetch_sched: directed slots plus a randomized
// stream compared against a first-opaque-layer-wins reference with one-slot latency.
module tb_layer_fetch_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_tick = 1'b0;
    logic [2:0]  layer_en = '0;
    logic [50:0] layer_addr = '0;
    logic [16:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic [11:0] pix_color;
    logic        pix_hit;
    logic [1:0]  pix_layer;
    logic        overrun;

    int testsRun = 0;
    int testsFailed = 0;

    logic [11:0] romMem [0:131071];

    layer_fetch_sched #(
        .N_LAYERS    (3),
        .CLK_PER_PIX (4),
        .TRANSPARENT (12'hF0F),
        .BG_COLOR    (12'h000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_tick   (pix_tick),
        .layer_en   (layer_en),
        .layer_addr (layer_addr),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix_color  (pix_color),
        .pix_hit    (pix_hit),
        .pix_layer  (pix_layer),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for the address seen in one cycle appears in the next.
    always @(posedge clk) rom_data <= romMem[rom_addr];

    // Reference: scan layers in priority order, first non-F0F texel wins.
    function automatic logic [14:0] refPixel(input logic [2:0] en, input logic [16:0] a0,
                                             input logic [16:0] a1, input logic [16:0] a2);
        logic [16:0] addrs [3];
        addrs[0] = a0;
        addrs[1] = a1;
        addrs[2] = a2;
        for (int i = 0; i < 3; i++) begin
            if (en[i] && romMem[addrs[i]] !== 12'hF0F) begin
                return {romMem[addrs[i]], 1'b1, 2'(i)};
            end
        end
        return {12'h000, 1'b0, 2'b00};
    endfunction

    // Called at a negedge: that cycle becomes the tick cycle; junk inputs follow it.
    task automatic applyStimulus(input logic [2:0] en, input logic [16:0] a0,
                                 input logic [16:0] a1, input logic [16:0] a2);
        pix_tick   = 1'b1;
        layer_en   = en;
        layer_addr = {a2, a1, a0};
        @(negedge clk);
        pix_tick   = 1'b0;
        layer_en   = 3'($urandom);
        layer_addr = {17'($urandom), 17'($urandom), 17'($urandom)};
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        idleCycles(2);
        testsRun++;
        if ({rom_addr, pix_color, pix_hit, pix_layer, overrun} !== 33'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_initial: got addr=%0d color=%h hit=%b layer=%0d ovr=%b required all 0",
                     rom_addr, pix_color, pix_hit, pix_layer, overrun);
        end
        rst = 1'b1;
        idleCycles(1);
        romMem[50] = 12'h5A5;
        applyStimulus(3'b001, 17'd50, 17'd0, 17'd0);
        idleCycles(3);
        applyStimulus(3'b111, 17'd50, 17'd51, 17'd52);
        testsRun++;
        if (pix_hit !== 1'b1 || pix_color !== 12'h5A5) begin
            testsFailed++;
            $display("[TB] FAIL reset_precondition: got hit=%b color=%h required hit=1 color=5a5", pix_hit, pix_color);
        end
        #2 rst = 1'b0;
        #1;
        testsRun++;
        if ({rom_addr, pix_color, pix_hit, pix_layer, overrun} !== 33'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_midscan: got addr=%0d color=%h hit=%b layer=%0d ovr=%b required all 0",
                     rom_addr, pix_color, pix_hit, pix_layer, overrun);
        end
        idleCycles(2);
        rst = 1'b1;
        idleCycles(1);
        romMem[60] = 12'h777;
        applyStimulus(3'b100, 17'd0, 17'd0, 17'd60);
        testsRun++;
        if (pix_hit !== 1'b0 || pix_color !== 12'h000 || overrun !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_first_commit: got hit=%b color=%h ovr=%b required 0/000/0", pix_hit, pix_color, overrun);
        end
        idleCycles(3);
        applyStimulus(3'b000, 17'd0, 17'd0, 17'd0);
        testsRun++;
        if (pix_hit !== 1'b1 || pix_color !== 12'h777 || pix_layer !== 2'd2 || overrun !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_clean_slot: got hit=%b color=%h layer=%0d ovr=%b required 1/777/2/0",
                     pix_hit, pix_color, pix_layer, overrun);
        end
        idleCycles(3);
    endtask

    task automatic test_single_layer();
        romMem[100] = 12'hABC;
        applyStimulus(3'b010, 17'd7, 17'd100, 17'd9);
        testsRun++;
        if (rom_addr !== 17'd100) begin
            testsFailed++;
            $display("[TB] FAIL single_rom_addr: got %0d required 100", rom_addr);
        end
        idleCycles(3);
        applyStimulus(3'b000, 17'd0, 17'd0, 17'd0);
        testsRun++;
        if (pix_color !== 12'hABC || pix_hit !== 1'b1 || pix_layer !== 2'd1) begin
            testsFailed++;
            $display("[TB] FAIL single_result: got color=%h hit=%b layer=%0d required abc/1/1", pix_color, pix_hit, pix_layer);
        end
        idleCycles(3);
    endtask

    task automatic test_fall_through();
        romMem[100] = 12'hF0F;
        romMem[200] = 12'h123;
        romMem[300] = 12'h456;
        applyStimulus(3'b111, 17'd100, 17'd200, 17'd300);
        testsRun++;
        if (rom_addr !== 17'd100) begin
            testsFailed++;
            $display("[TB] FAIL fall_addr_first: got %0d required 100", rom_addr);
        end
        idleCycles(1);
        testsRun++;
        if (rom_addr !== 17'd200) begin
            testsFailed++;
            $display("[TB] FAIL fall_addr_second: got %0d required 200", rom_addr);
        end
        idleCycles(2);
        applyStimulus(3'b000, 17'd0, 17'd0, 17'd0);
        testsRun++;
        if (pix_color !== 12'h123 || pix_hit !== 1'b1 || pix_layer !== 2'd1) begin
            testsFailed++;
            $display("[TB] FAIL fall_result: got color=%h hit=%b layer=%0d required 123/1/1", pix_color, pix_hit, pix_layer);
        end
        idleCycles(3);
    endtask

    task automatic test_empty();
        romMem[100] = 12'hABC;
        applyStimulus(3'b010, 17'd0, 17'd100, 17'd0);
        idleCycles(3);
        applyStimulus(3'b000, 17'd100, 17'd100, 17'd100);
        testsRun++;
        if (pix_color !== 12'hABC || pix_hit !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL empty_precondition: got color=%h hit=%b required abc/1", pix_color, pix_hit);
        end
        idleCycles(3);
        applyStimulus(3'b111, 17'd400, 17'd500, 17'd600);
        testsRun++;
        if (pix_color !== 12'h000 || pix_hit !== 1'b0 || pix_layer !== 2'd0 || overrun !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL empty_no_layers: got color=%h hit=%b layer=%0d ovr=%b required 000/0/0/0",
                     pix_color, pix_hit, pix_layer, overrun);
        end
        idleCycles(3);
        applyStimulus(3'b000, 17'd0, 17'd0, 17'd0);
        testsRun++;
        if (pix_color !== 12'h000 || pix_hit !== 1'b0 || pix_layer !== 2'd0 || overrun !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL empty_all_transparent: got color=%h hit=%b layer=%0d ovr=%b required 000/0/0/0",
                     pix_color, pix_hit, pix_layer, overrun);
        end
        idleCycles(3);
    endtask

    task automatic test_overrun();
        romMem[100] = 12'hABC;
        applyStimulus(3'b111, 17'd400, 17'd500, 17'd600);
        idleCycles(1);
        applyStimulus(3'b010, 17'd0, 17'd100, 17'd0);
        testsRun++;
        if (pix_color !== 12'h000 || pix_hit !== 1'b0 || overrun !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL overrun_set: got color=%h hit=%b ovr=%b required 000/0/1", pix_color, pix_hit, overrun);
        end
        idleCycles(3);
        applyStimulus(3'b000, 17'd0, 17'd0, 17'd0);
        testsRun++;
        if (pix_color !== 12'hABC || pix_layer !== 2'd1 || overrun !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL overrun_sticky: got color=%h layer=%0d ovr=%b required abc/1/1", pix_color, pix_layer, overrun);
        end
        idleCycles(3);
        applyStimulus(3'b000, 17'd0, 17'd0, 17'd0);
        testsRun++;
        if (overrun !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL overrun_sticky_later: got ovr=%b required 1", overrun);
        end
        idleCycles(2);
        rst = 1'b0;
        #1;
        testsRun++;
        if (overrun !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL overrun_reset_clear: got ovr=%b required 0", overrun);
        end
        idleCycles(1);
        rst = 1'b1;
        idleCycles(1);
    endtask

    task automatic test_streaming();
        logic [14:0] expPrev;
        logic [14:0] expNext;
        logic [2:0]  en;
        logic [16:0] a0, a1, a2;
        for (int i = 0; i < 64; i++) begin
            romMem[i] = ($urandom_range(0, 1) == 0) ? 12'hF0F : 12'($urandom);
        end
        expPrev = 15'd0;
        for (int s = 0; s <= 1000; s++) begin
            en = (s == 1000) ? 3'b000 : 3'($urandom);
            a0 = 17'($urandom_range(0, 63));
            a1 = 17'($urandom_range(0, 63));
            a2 = 17'($urandom_range(0, 63));
            expNext = refPixel(en, a0, a1, a2);
            applyStimulus(en, a0, a1, a2);
            testsRun++;
            if ({pix_color, pix_hit, pix_layer} !== expPrev) begin
                testsFailed++;
                $display("[TB] FAIL stream_slot%0d: got color=%h hit=%b layer=%0d required color=%h hit=%b layer=%0d",
                         s, pix_color, pix_hit, pix_layer, expPrev[14:3], expPrev[2], expPrev[1:0]);
            end
            testsRun++;
            if (overrun !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL stream_overrun%0d: got %b required 0", s, overrun);
            end
            expPrev = expNext;
            idleCycles($urandom_range(3, 5));
        end
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) begin
            romMem[i] = 12'hF0F;
        end
        test_reset();
        test_single_layer();
        test_fall_through();
        test_empty();
        test_overrun();
        test_streaming();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
